lsu_replay_scheduler: RTL and testbench

- Schedules replay of violating or missed loads onto the single load port of the LSU datapath. That port is shared with fresh AGEN memory packets.
- Buffers pending replay load-queue IDs in a small FIFO. Issues one replay when the AGEN slot is idle.
- Guarantees forward progress by stalling AGEN for one slot after sustained starvation.
- Flushes on branch/exception recovery.

---
 rtl/lsu_replay_scheduler.sv | 140 ++++++++++++++
 tb/tb_lsu_replay_scheduler.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_replay_scheduler.sv
// Replay scheduler for the shared LSU load port: buffers replay load IDs in a FIFO and
// issues them into idle AGEN slots, forcing a stalled slot after sustained starvation.
module lsu_replay_scheduler #(
  parameter int QDEPTH       = 4,
  parameter int ID_W         = 5,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         recoverFlag_i,
  input  logic                         replayReq_i,
  input  logic [ID_W-1:0]              replayLdqID_i,
  output logic                         replayReqReady_o,
  output logic                         replayOverflow_o,
  input  logic                         agenValid_i,
  input  logic                         mshrFull_i,
  output logic                         agenStall_o,
  output logic                         replayIssue_o,
  output logic [ID_W-1:0]              replayIssueID_o,
  output logic [$clog2(QDEPTH+1)-1:0]  occupancy_o
);

  localparam int CW = $clog2(QDEPTH + 1);
  localparam int PW = $clog2(QDEPTH);
  localparam int SW = $clog2(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE,
    ARB,
    FORCE
  } state_t;

  state_t          state;
  logic [ID_W-1:0] fifo [QDEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_next;
  logic [SW-1:0]   starve;
  logic            not_empty;
  logic            full;
  logic            push;
  logic            pop;
  logic            blocked;
  logic            starve_hit;

  assign not_empty = (count != '0);
  assign full      = (count == CW'(QDEPTH));

  // In FORCE the AGEN port is held off, so agenValid_i no longer competes for the slot.
  assign replayIssue_o = not_empty & ~mshrFull_i & ~recoverFlag_i &
                         (~agenValid_i | (state == FORCE));
  assign pop  = replayIssue_o;
  assign push = replayReq_i & ~full & ~recoverFlag_i;

  assign blocked    = not_empty & agenValid_i & ~replayIssue_o & (state == ARB);
  assign starve_hit = blocked & (starve == SW'(STARVE_LIMIT - 1));

  assign count_next = count + CW'(push) - CW'(pop);

  assign replayIssueID_o  = not_empty ? fifo[head] : '0;
  assign replayReqReady_o = ~full;
  assign occupancy_o      = count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        fifo[i] <= '0;
      end
    end else if (recoverFlag_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        fifo[tail] <= replayLdqID_i;
        tail       <= tail + PW'(1);
      end
      if (pop) begin
        head <= head + PW'(1);
      end
      count <= count_next;
    end
  end

  // Arbitration FSM; agenStall_o tracks FORCE as a registered output.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      starve           <= '0;
      agenStall_o      <= 1'b0;
      replayOverflow_o <= 1'b0;
    end else if (recoverFlag_i) begin
      state            <= IDLE;
      starve           <= '0;
      agenStall_o      <= 1'b0;
      replayOverflow_o <= 1'b0;
    end else begin
      replayOverflow_o <= replayReq_i & full;
      case (state)
        IDLE: begin
          starve <= '0;
          if (push) begin
            state <= ARB;
          end
        end
        ARB: begin
          if (starve_hit) begin
            state       <= FORCE;
            starve      <= '0;
            agenStall_o <= 1'b1;
          end else if (pop) begin
            starve <= '0;
            if (count_next == '0) begin
              state <= IDLE;
            end
          end else if (blocked) begin
            starve <= starve + SW'(1);
          end
        end
        FORCE: begin
          if (pop) begin
            starve      <= '0;
            agenStall_o <= 1'b0;
            state       <= (count_next != '0) ? ARB : IDLE;
          end
        end
        default: begin
          state       <= IDLE;
          starve      <= '0;
          agenStall_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_replay_scheduler.sv
// Self-checking bench for lsu_replay_scheduler: directed scenarios plus random traffic,
// all compared against a queue-based reference model of the replay rules.
module tb_lsu_replay_scheduler;

  localparam int QDEPTH       = 4;
  localparam int ID_W         = 5;
  localparam int STARVE_LIMIT = 8;
  localparam int OCC_W        = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              recoverFlag_i;
  logic              replayReq_i;
  logic [ID_W-1:0]   replayLdqID_i;
  logic              replayReqReady_o;
  logic              replayOverflow_o;
  logic              agenValid_i;
  logic              mshrFull_i;
  logic              agenStall_o;
  logic              replayIssue_o;
  logic [ID_W-1:0]   replayIssueID_o;
  logic [OCC_W-1:0]  occupancy_o;

  int errors = 0;
  int checks = 0;

  // Reference model: the FIFO is a queue, "forced" marks a granted starvation slot.
  logic [ID_W-1:0] m_q[$];
  bit              m_forced;
  int              m_starve;
  bit              m_ovf;

  logic            exp_issue;
  logic [ID_W-1:0] exp_id;
  logic [11:0]     exp_vec;
  logic [11:0]     obs_vec;

  assign obs_vec = {replayIssue_o, replayIssueID_o, occupancy_o, agenStall_o,
                    replayOverflow_o, replayReqReady_o};

  lsu_replay_scheduler #(
    .QDEPTH(QDEPTH), .ID_W(ID_W), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk), .reset(reset), .recoverFlag_i(recoverFlag_i),
    .replayReq_i(replayReq_i), .replayLdqID_i(replayLdqID_i),
    .replayReqReady_o(replayReqReady_o), .replayOverflow_o(replayOverflow_o),
    .agenValid_i(agenValid_i), .mshrFull_i(mshrFull_i), .agenStall_o(agenStall_o),
    .replayIssue_o(replayIssue_o), .replayIssueID_o(replayIssueID_o),
    .occupancy_o(occupancy_o)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_q.delete();
    m_forced = 1'b0;
    m_starve = 0;
    m_ovf    = 1'b0;
  endtask

  // Applies one cycle of inputs after the falling edge and computes the expected outputs.
  task automatic drive(input logic req, input logic [ID_W-1:0] id, input logic agen,
                       input logic mshr, input logic rec);
    @(negedge clk);
    replayReq_i   = req;
    replayLdqID_i = id;
    agenValid_i   = agen;
    mshrFull_i    = mshr;
    recoverFlag_i = rec;
    #1;
    exp_issue = (m_q.size() != 0) && !mshr && !rec && (!agen || m_forced);
    exp_id    = (m_q.size() != 0) ? m_q[0] : '0;
    exp_vec   = {exp_issue, exp_id, OCC_W'(m_q.size()), m_forced, m_ovf,
                 (m_q.size() < QDEPTH)};
  endtask

  task automatic tick();
    bit accept;
    bit blocked;
    @(posedge clk);
    if (recoverFlag_i) begin
      model_reset();
    end else begin
      accept  = replayReq_i && (m_q.size() < QDEPTH);
      m_ovf   = replayReq_i && (m_q.size() == QDEPTH);
      blocked = (m_q.size() != 0) && agenValid_i && !exp_issue && !m_forced;
      if (exp_issue) void'(m_q.pop_front());
      if (accept) m_q.push_back(replayLdqID_i);
      if (m_forced) begin
        if (exp_issue) begin
          m_forced = 1'b0;
          m_starve = 0;
        end
      end else if (blocked) begin
        if (m_starve == STARVE_LIMIT - 1) begin
          m_forced = 1'b1;
          m_starve = 0;
        end else begin
          m_starve++;
        end
      end else if (exp_issue) begin
        m_starve = 0;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    replayReq_i = 0; replayLdqID_i = '0; agenValid_i = 0; mshrFull_i = 0; recoverFlag_i = 0;
    model_reset();
    repeat (2) @(negedge clk);
    replayReq_i = 1'b1;
    #1;
    checks++;
    if (obs_vec !== 12'h001) begin
      errors++;
      $display("[TB] FAIL reset outs got=%h exp=%h", obs_vec, 12'h001);
    end
    @(negedge clk);
    replayReq_i = 1'b0;
    reset = 1'b1;
  endtask

  task automatic test_basic();
    logic [ID_W-1:0] got[$];
    for (int i = 0; i < 5; i++) begin
      drive(i < 2, (i == 0) ? ID_W'(3) : ID_W'(7), 1'b0, 1'b0, 1'b0);
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("[TB] FAIL basic cyc=%0d outs got=%h exp=%h", i, obs_vec, exp_vec);
      end
      if (replayIssue_o) got.push_back(replayIssueID_o);
      tick();
    end
    checks++;
    if (got.size() != 2 || got[0] !== ID_W'(3) || got[1] !== ID_W'(7)) begin
      errors++;
      $display("[TB] FAIL basic_order got_count=%0d exp_count=2", got.size());
    end
  endtask

  task automatic test_overflow();
    logic [ID_W-1:0] pushed[5];
    logic [ID_W-1:0] got[$];
    int ovf_seen = 0;
    for (int i = 0; i < 5; i++) pushed[i] = ID_W'($urandom_range(0, 31));
    for (int i = 0; i < 11; i++) begin
      drive(i < 5, pushed[(i < 5) ? i : 0], i < 5, 1'b0, 1'b0);
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("[TB] FAIL overflow cyc=%0d outs got=%h exp=%h", i, obs_vec, exp_vec);
      end
      if (replayOverflow_o) ovf_seen++;
      if (replayIssue_o) got.push_back(replayIssueID_o);
      tick();
    end
    checks++;
    if (ovf_seen != 1) begin
      errors++;
      $display("[TB] FAIL overflow_pulses got=%0d exp=1", ovf_seen);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (got.size() <= i || got[i] !== pushed[i]) begin
        errors++;
        $display("[TB] FAIL overflow_drain idx=%0d got_count=%0d exp_id=%0d", i, got.size(), pushed[i]);
      end
    end
  endtask

  task automatic test_starve();
    int first_stall = -1;
    int issue_idx   = -1;
    for (int i = 0; i < 13; i++) begin
      drive(i == 0, ID_W'(9), 1'b1, 1'b0, 1'b0);
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("[TB] FAIL starve cyc=%0d outs got=%h exp=%h", i, obs_vec, exp_vec);
      end
      if (agenStall_o && first_stall < 0) first_stall = i;
      if (replayIssue_o && replayIssueID_o === ID_W'(9) && issue_idx < 0) issue_idx = i;
      tick();
    end
    checks++;
    if (first_stall != 9 || issue_idx != 9) begin
      errors++;
      $display("[TB] FAIL starve_timing got_stall=%0d got_issue=%0d exp=9", first_stall, issue_idx);
    end
  endtask

  task automatic test_force_mshr();
    int issue_idx = -1;
    for (int i = 0; i < 15; i++) begin
      drive(i == 0, ID_W'(12), 1'b1, (i >= 9 && i <= 11), 1'b0);
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("[TB] FAIL force_mshr cyc=%0d outs got=%h exp=%h", i, obs_vec, exp_vec);
      end
      if (replayIssue_o && issue_idx < 0) issue_idx = i;
      tick();
    end
    checks++;
    if (issue_idx != 12) begin
      errors++;
      $display("[TB] FAIL force_mshr_issue got=%0d exp=12", issue_idx);
    end
  endtask

  task automatic test_recovery();
    for (int i = 0; i < 5; i++) begin
      drive(i <= 3, ID_W'(20 + i), i < 3, 1'b0, i == 3);
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("[TB] FAIL recovery cyc=%0d outs got=%h exp=%h", i, obs_vec, exp_vec);
      end
      tick();
    end
    for (int i = 0; i < 13; i++) begin
      drive(i == 0, ID_W'(17), 1'b1, i >= 9, i == 11);
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("[TB] FAIL recovery_force cyc=%0d outs got=%h exp=%h", i, obs_vec, exp_vec);
      end
      tick();
    end
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (agenStall_o !== 1'b0 || occupancy_o !== '0) begin
      errors++;
      $display("[TB] FAIL recovery_clear got_stall=%0b got_occ=%0d exp=0", agenStall_o, occupancy_o);
    end
    tick();
  endtask

  task automatic test_wrap();
    logic [ID_W-1:0] pushed[$];
    logic [ID_W-1:0] got[$];
    logic [ID_W-1:0] id;
    for (int i = 0; i < 18; i++) begin
      id = ID_W'($urandom_range(0, 31));
      if (i < 12) pushed.push_back(id);
      drive(i < 12, id, i < 2, 1'b0, 1'b0);
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("[TB] FAIL wrap cyc=%0d outs got=%h exp=%h", i, obs_vec, exp_vec);
      end
      if (replayIssue_o) got.push_back(replayIssueID_o);
      tick();
    end
    checks++;
    if (got != pushed) begin
      errors++;
      $display("[TB] FAIL wrap_order got_count=%0d exp_count=%0d", got.size(), pushed.size());
    end
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 11; i++) begin
      drive(i == 0, ID_W'(5), 1'b1, i >= 9, 1'b0);
      if (i < 10) tick();
    end
    checks++;
    if (agenStall_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_reset_pre got=%0b exp=1", agenStall_o);
    end
    #1 reset = 1'b0;
    #1;
    checks++;
    if (agenStall_o !== 1'b0 || occupancy_o !== '0) begin
      errors++;
      $display("[TB] FAIL mid_reset got_stall=%0b got_occ=%0d exp=0", agenStall_o, occupancy_o);
    end
    model_reset();
    @(negedge clk);
    replayReq_i = 0; agenValid_i = 0; mshrFull_i = 0; recoverFlag_i = 0;
    reset = 1'b1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      drive($urandom_range(0, 99) < 50, ID_W'($urandom_range(0, 31)),
            $urandom_range(0, 99) < 75, $urandom_range(0, 99) < 20,
            $urandom_range(0, 99) < 3);
      checks++;
      if (obs_vec !== exp_vec) begin
        errors++;
        $display("[TB] FAIL random cyc=%0d outs got=%h exp=%h", i, obs_vec, exp_vec);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_starve();
    test_force_mshr();
    test_recovery();
    test_wrap();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
